// File: rtl/alu_op_scheduler.sv
// Two-requester front end for one shared ALU: round-robin grant,
// opcode legality screening, one-cycle execute, held response.
module alu_op_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_cin,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_cout,
  output logic               resp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_n;
  logic ptr;

  logic [1:0]       gnt;
  logic             gid;
  logic [3:0]       g_op;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_b;
  logic             g_cin;
  logic             g_legal;

  // A lone requester wins outright; ptr only breaks ties.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req_valid[0] & (~req_valid[1] | ~ptr);
    gnt[1] = req_valid[1] & (~req_valid[0] | ptr);
    gid    = gnt[1];
    g_op   = gid ? req_op[7:4] : req_op[3:0];
    g_a    = gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    g_b    = gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    g_cin  = gid ? req_cin[1] : req_cin[0];
    g_legal = (g_op <= 4'd10) &&
              !((g_op == 4'd8) && (g_b == '0));
  end

  always_comb begin
    state_n   = state;
    req_ready = 2'b00;
    unique case (state)
      IDLE: begin
        req_ready = gnt;
        if (|gnt)
          state_n = g_legal ? EXEC : RESP;
      end
      EXEC: state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Illegal grants leave the ALU operand registers untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cin     <= 1'b0;
      alu_op      <= 4'd0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_cout   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            resp_id <= gid;
            if (g_legal) begin
              alu_a   <= g_a;
              alu_b   <= g_b;
              alu_cin <= g_cin;
              alu_op  <= g_op;
            end else begin
              resp_result <= '0;
              resp_cout   <= 1'b0;
              resp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_cout   <= (alu_op == 4'd5) & alu_cout;
          resp_err    <= 1'b0;
        end
        RESP: begin
          if (resp_ready)
            ptr <= ~resp_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a behavioural ALU
// whose carry-out is always the adder carry, whatever the opcode.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_cin;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [3:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [7:0]  resp_result;
  logic        resp_cout;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_cout(resp_cout), .resp_err(resp_err),
    .busy(busy)
  );

  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    alu_cout = sum[8];
    case (alu_op)
      4'd2:    alu_result = alu_a & alu_b;
      4'd5:    alu_result = sum[7:0];
      4'd6:    alu_result = alu_a - alu_b;
      4'd7:    alu_result = {alu_a[6:0], 1'b0};
      4'd8:    alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic drive_req(input int id, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
    req_valid[id]       = 1'b1;
    req_op[id*4 +: 4]   = op;
    req_a[id*8 +: 8]    = a;
    req_b[id*8 +: 8]    = b;
    req_cin[id]         = cin;
  endtask

  task automatic drain();
    int n;
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", busy, 1'b0);
    resp_ready = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [3:0] prev_op;
    int n;
    @(negedge clk);
    prev_op    = alu_op;
    resp_ready = 1'b0;
    drive_req(v.id, v.op, v.a, v.b, v.cin);
    #1;
    chk($sformatf("v%0d_ready", k), req_ready, 2'b01 << v.id);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_a     = ~req_a;
    req_b     = ~req_b;
    req_op    = ~req_op;
    req_cin   = ~req_cin;
    if (v.err)
      chk($sformatf("v%0d_aluop_kept", k), alu_op, prev_op);
    n = 1;
    while (!resp_valid && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_latency", k), n, v.err ? 1 : 2);
    chk($sformatf("v%0d_resp", k),
        {resp_valid, resp_id, resp_result, resp_cout, resp_err, busy},
        {1'b1, v.id[0], v.res, v.cout, v.err, 1'b1});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_done", k), {resp_valid, busy}, 2'b00);
    resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic g;
    logic [7:0] hold_res;
    vecs[0] = '{0, 4'd5,  8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[1] = '{1, 4'd8,  8'h09, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{0, 4'hC,  8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{0, 4'd7,  8'h0E, 8'hFF, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[4] = '{1, 4'd6,  8'h50, 8'h21, 1'b0, 8'h2F, 1'b0, 1'b0};
    vecs[5] = '{1, 4'd5,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{0, 4'd8,  8'h09, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[7] = '{1, 4'd10, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{0, 4'd11, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{1, 4'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid = 2'b00; req_op = 8'h00; req_a = 16'h0;
    req_b = 16'h0; req_cin = 2'b00; resp_ready = 1'b0;
    #1;
    chk("reset_outputs",
        {req_ready, resp_valid, resp_id, resp_result, resp_cout,
         resp_err, busy, alu_a, alu_b, alu_cin, alu_op}, 64'd0);
    #2 rst = 1'b0;

    for (int k = 0; k < 10; k++)
      run_vec(k, vecs[k]);

    // Round-robin under continuous contention, from reset.
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    resp_ready = 1'b1;
    drive_req(0, 4'd2, 8'hFF, 8'h0F, 1'b0);
    drive_req(1, 4'd2, 8'hFF, 8'hF0, 1'b0);
    for (int gi = 0; gi < 4; gi++) begin
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 6) begin
        @(negedge clk); #1;
        n++;
      end
      chk($sformatf("rr_grant%0d", gi), req_ready,
          (gi % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
    end
    #1;
    drain();

    // Held response under contention, then hand-off.
    @(negedge clk);
    resp_ready = 1'b0;
    drive_req(0, 4'd5, 8'h01, 8'h02, 1'b0);
    drive_req(1, 4'd5, 8'h10, 8'h20, 1'b0);
    #1;
    g = req_ready[1];
    chk("hold_grant", req_ready, 2'b01);
    hold_res = g ? 8'h30 : 8'h03;
    @(posedge clk);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", c),
          {req_ready, resp_valid, resp_id, resp_result, resp_cout,
           resp_err, busy},
          {2'b00, 1'b1, g, hold_res, 1'b0, 1'b0, 1'b1});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {resp_valid, busy}, 2'b00);
    @(negedge clk); #1;
    chk("hold_next_grant", req_ready, g ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    drain();

    // Reset while a subtract is executing.
    @(negedge clk);
    drive_req(0, 4'd6, 8'h09, 8'h03, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("abort_in_exec", {busy, resp_valid}, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outputs",
        {req_ready, resp_valid, resp_id, resp_result, resp_cout,
         resp_err, busy, alu_a, alu_b, alu_cin, alu_op}, 64'd0);
    #2 rst = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width of the shared ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid; bit k = requester k.
REQ-005 req_ready  output  2  per-requester accept strobe; combinational.
REQ-006 req_op  input  8  packed opcodes, [3:0] requester 0, [7:4] requester 1.
REQ-007 req_a  input  2*WIDTH  packed operand A, low half requester 0.
REQ-008 req_b  input  2*WIDTH  packed operand B, low half requester 0.
REQ-009 req_cin  input  2  per-requester carry-in.
REQ-010 alu_a, alu_b  output  WIDTH each  operands to shared ALU.
REQ-011 alu_cin  output  1  carry-in to shared ALU.
REQ-012 alu_op  output  4  opcode to shared ALU.
REQ-013 alu_result  input  WIDTH  combinational ALU result.
REQ-014 alu_cout  input  1  combinational ALU carry-out.
REQ-015 resp_valid  output  1  response valid.
REQ-016 resp_ready  input  1  response accept by the consumer.
REQ-017 resp_id  output  1  requester that owns the response.
REQ-018 resp_result  output  WIDTH  captured result.
REQ-019 resp_cout  output  1  captured carry-out.
REQ-020 resp_err  output  1  request rejected as illegal.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-023 IDLE: if any req_valid bit set, grant one requester, assert req_ready for that bit only in that cycle, latch its op/a/b/cin and id.
REQ-024 Arbitration SHALL be round-robin: pointer selects preferred requester when both valid; a lone valid requester is granted regardless of pointer.
REQ-025 Pointer SHALL move to the non-granted requester when a response is accepted (RESP with resp_ready=1).
REQ-026 Legal op: opcode 0000-1010, except 1000 (divide) with B=0.
REQ-027 Legal op: IDLE -> EXEC; in EXEC, alu_result/alu_cout captured at clock edge; EXEC -> RESP unconditionally (one EXEC cycle).
REQ-028 Illegal op: IDLE -> RESP directly; resp_result=0, resp_cout=0, resp_err=1; EXEC skipped.
REQ-029 resp_cout SHALL equal captured alu_cout only for opcode 0101 (add); 0 for all other opcodes.
REQ-030 resp_err SHALL be 0 for every legal op.
REQ-031 alu_a/alu_b/alu_cin/alu_op SHALL be driven from latched registers in all states; they change only on a grant.
REQ-032 RESP: resp_valid=1, resp_id/result/cout/err stable until resp_ready=1; on resp_ready=1, -> IDLE and resp_valid falls next cycle.
REQ-033 Latency: grant at edge N, legal response visible after edge N+2; illegal after edge N+1.
REQ-034 No new grant SHALL occur in EXEC or RESP; req_ready=00 there regardless of req_valid.
REQ-035 A grant SHALL NOT occur in the same cycle a response is accepted; earliest next grant is the cycle after return to IDLE.
REQ-036 Operand changes on req_* after grant SHALL NOT affect the transaction in flight.

Reset
REQ-037 rst=1 SHALL force, immediately and regardless of clk: state IDLE, pointer=0 (requester 0 preferred), req_ready=00, resp_valid=0, resp_id=0, resp_result=0, resp_cout=0, resp_err=0, busy=0, alu_a=0, alu_b=0, alu_cin=0, alu_op=0000.
REQ-038 Reset during EXEC or RESP SHALL abort the transaction with no response emitted after release.
REQ-039 First grant SHALL be possible in the first clk edge with rst=0.

Verification
REQ-040 Req0 ADD a=8'hF0 b=8'h20 cin=1, resp_ready=1 -> req_ready=01, resp_valid 2 edges later, id=0, result=8'h11, cout=1, err=0.
REQ-041 Both valid continuously, op AND, resp_ready=1 -> grants alternate 0,1,0,1 starting with requester 0 after reset.
REQ-042 Req1 DIVIDE a=8'h09 b=8'h00 -> resp_valid after 1 edge, id=1, result=0, cout=0, err=1; alu_op unchanged from prior value.
REQ-043 Req0 opcode 4'b1100 -> err=1, result=0; Req0 SHIFT LEFT a=8'h0E -> result=8'h1C, cout=0, err=0.
REQ-044 Response held with resp_ready=0 for 5 cycles while req_valid=11 -> resp fields stable, req_ready=00, busy=1; release -> IDLE, next grant to other requester.
REQ-045 rst asserted mid-EXEC of SUBTRACT -> all outputs zero immediately, no resp_valid after rst release until a new request.
